digit_shift_queue: RTL and testbench

Parametrised digit shift queue feeding the multiplexed 7-segment display path. New digits enter at position 0 and older digits move up one position; the block adds backspace (pop), in-place edit, clear, overwrite-on-full mode, occupancy count, per-digit valid mask for blanking, and sticky overflow/underflow flags. It sits between the debounced switch/button front end and the 7-segment scanner.

---
 rtl/digit_shift_queue.sv | 126 ++++++++++++
 tb/tb_digit_shift_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/digit_shift_queue.sv
// Digit shift queue for the 7-segment path: newest digit at shr[0], with backspace, edit, clear and rotate.
// Define DIGIT_SHIFT_QUEUE_ROTATE_EN to build the rotate datapath; otherwise the rot input is ignored.
module digit_shift_queue #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 4,
  parameter int OVERWRITE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 data_in,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             clear,
  input  logic                             rot,
  output logic [DEPTH-1:0][WIDTH-1:0]      shr,
  output logic [DEPTH-1:0]                 valid,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty,
  output logic                             ovf,
  output logic                             udf
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] shr_q, shr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic                        udf_q, udf_d;
  logic                        isFull, isEmpty;

  assign isFull  = (count_q == CW'(DEPTH));
  assign isEmpty = (count_q == '0);

`ifdef DIGIT_SHIFT_QUEUE_ROTATE_EN
  logic [WIDTH-1:0] rotTop;
`else
  logic unused_rot;
  assign unused_rot = rot;
`endif

  // Digits above count are kept at zero by every path, so a shift-in never carries stale data.
  always_comb begin
    shr_d   = shr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
`ifdef DIGIT_SHIFT_QUEUE_ROTATE_EN
    rotTop  = '0;
`endif
    if (clear) begin
      shr_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (push && (!pop || isEmpty)) begin
      if (!isFull || OVERWRITE != 0) begin
        shr_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
          shr_d[i] = shr_q[i-1];
        end
        if (!isFull) begin
          count_d = count_q + CW'(1);
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (push && pop) begin
      shr_d[0] = data_in;
    end else if (pop) begin
      if (isEmpty) begin
        udf_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH-1; i++) begin
          shr_d[i] = shr_q[i+1];
        end
        shr_d[DEPTH-1] = '0;
        count_d        = count_q - CW'(1);
      end
    end
`ifdef DIGIT_SHIFT_QUEUE_ROTATE_EN
    else if (rot && !isEmpty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i+1) == count_q) begin
          rotTop = shr_q[i];
        end
      end
      shr_d[0] = rotTop;
      for (int i = 1; i < DEPTH; i++) begin
        if (CW'(i) < count_q) begin
          shr_d[i] = shr_q[i-1];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      shr_q   <= shr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(i) < count_q);
    end
  end

  assign shr   = shr_q;
  assign count = count_q;
  assign full  = isFull;
  assign empty = isEmpty;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_digit_shift_queue.sv
// Scoreboard bench: drives a drop-on-full and an overwrite-on-full instance with the same stimulus
// and checks both against a queue-based reference model.
module tb_digit_shift_queue;

  typedef struct packed {
    logic [15:0] shr;
    logic [2:0]  count;
    logic [3:0]  valid;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;
  } exp_t;

  logic clk;
  logic rst, push, pop, clear, rot;
  logic [3:0] dataIn;

  logic [3:0][3:0] shr0, shr1;
  logic [3:0]      valid0, valid1;
  logic [2:0]      count0, count1;
  logic            full0, full1, empty0, empty1, ovf0, ovf1, udf0, udf1;

  int total = 0;
  int bad   = 0;

  logic [3:0] mq [2][$];
  logic       ovfM [2];
  logic       udfM [2];
  exp_t       expQ [2][$];

  digit_shift_queue #(.DEPTH(4), .WIDTH(4), .OVERWRITE(0)) dutDrop (
    .clk(clk), .rst(rst), .data_in(dataIn), .push(push), .pop(pop), .clear(clear), .rot(rot),
    .shr(shr0), .valid(valid0), .count(count0), .full(full0), .empty(empty0), .ovf(ovf0), .udf(udf0)
  );

  digit_shift_queue #(.DEPTH(4), .WIDTH(4), .OVERWRITE(1)) dutOver (
    .clk(clk), .rst(rst), .data_in(dataIn), .push(push), .pop(pop), .clear(clear), .rot(rot),
    .shr(shr1), .valid(valid1), .count(count1), .full(full1), .empty(empty1), .ovf(ovf1), .udf(udf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the queue holds occupied digits, newest first.
  task automatic modelStep(input int k, input bit rs, input bit cl, input bit ps, input bit pp,
                           input bit rt, input logic [3:0] d);
    exp_t e;
    if (rs || cl) begin
      mq[k].delete();
      ovfM[k] = 1'b0;
      udfM[k] = 1'b0;
    end else if (ps && (!pp || mq[k].size() == 0)) begin
      if (mq[k].size() < 4) begin
        mq[k].push_front(d);
      end else if (k == 1) begin
        void'(mq[k].pop_back());
        mq[k].push_front(d);
      end else begin
        ovfM[k] = 1'b1;
      end
    end else if (ps && pp) begin
      mq[k][0] = d;
    end else if (pp) begin
      if (mq[k].size() == 0) udfM[k] = 1'b1;
      else void'(mq[k].pop_front());
    end
`ifdef DIGIT_SHIFT_QUEUE_ROTATE_EN
    else if (rt && mq[k].size() > 0) begin
      logic [3:0] last;
      last = mq[k].pop_back();
      mq[k].push_front(last);
    end
`endif
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < mq[k].size()) begin
        e.shr[i*4 +: 4] = mq[k][i];
        e.valid[i]      = 1'b1;
      end
    end
    e.count = 3'(mq[k].size());
    e.full  = (mq[k].size() == 4);
    e.empty = (mq[k].size() == 0);
    e.ovf   = ovfM[k];
    e.udf   = udfM[k];
    expQ[k].push_back(e);
  endtask

  task automatic applyStimulus(input bit rs, input bit cl, input bit ps, input bit pp,
                               input bit rt, input logic [3:0] d);
    @(negedge clk);
    rst    = rs;
    clear  = cl;
    push   = ps;
    pop    = pp;
    rot    = rt;
    dataIn = d;
    modelStep(0, rs, cl, ps, pp, rt, d);
    modelStep(1, rs, cl, ps, pp, rt, d);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input int k, input exp_t e, input logic [15:0] s, input logic [2:0] c,
                          input logic [3:0] v, input logic f, input logic em, input logic o,
                          input logic u);
    checkOutput($sformatf("dut%0d.shr", k),   s,         e.shr);
    checkOutput($sformatf("dut%0d.count", k), 16'(c),    16'(e.count));
    checkOutput($sformatf("dut%0d.valid", k), 16'(v),    16'(e.valid));
    checkOutput($sformatf("dut%0d.full", k),  16'(f),    16'(e.full));
    checkOutput($sformatf("dut%0d.empty", k), 16'(em),   16'(e.empty));
    checkOutput($sformatf("dut%0d.ovf", k),   16'(o),    16'(e.ovf));
    checkOutput($sformatf("dut%0d.udf", k),   16'(u),    16'(e.udf));
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ[0].size() > 0) begin
        e = expQ[0].pop_front();
        checkDut(0, e, shr0, count0, valid0, full0, empty0, ovf0, udf0);
      end
      if (expQ[1].size() > 0) begin
        e = expQ[1].pop_front();
        checkDut(1, e, shr1, count1, valid1, full1, empty1, ovf1, udf1);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; rot = 1'b0; dataIn = '0;
    ovfM[0] = 1'b0; ovfM[1] = 1'b0; udfM[0] = 1'b0; udfM[1] = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 0, 0, 4'(i));
    applyStimulus(0, 0, 1, 0, 0, 4'd5);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 4'd7);
    applyStimulus(0, 0, 1, 0, 0, 4'd1);
    applyStimulus(0, 0, 1, 1, 0, 4'd9);
    applyStimulus(0, 0, 1, 0, 0, 4'd2);
    applyStimulus(0, 0, 1, 0, 0, 4'd3);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 4'(i + 10));
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 4'd6);
    applyStimulus(0, 0, 1, 0, 0, 4'd8);
    applyStimulus(0, 1, 1, 1, 1, 4'd4);

    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 25, 4'($urandom_range(0, 15)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (expQ[0].size() != 0 || expQ[1].size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d/%0d pending expected 0", expQ[0].size(), expQ[1].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
